display_arbiter: RTL and testbench

DISPLAY_ARBITER -- requirements
Module: display_arbiter

---
 rtl/display_arbiter.sv | 126 ++++++++++++
 tb/tb_display_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/display_arbiter.sv
// Arbitrates three display sources (time, countdown, alert) onto one 8-digit driver.
// Alert preempts immediately; time and countdown share the display round-robin with a minimum hold.
module display_arbiter #(
  parameter int unsigned TICK_PERIOD = 100_000_000,
  parameter int unsigned HOLD_TICKS  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  output logic [2:0]  gnt,
  output logic [1:0]  owner,
  output logic [31:0] time_data
);

  localparam int unsigned CNT_W  = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam int unsigned HOLD_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [31:0] BLANK  = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN    = 2'd1,
    SWITCH = 2'd2
  } state_e;

  state_e            state_q;
  logic [2:0]        gnt_q;
  logic [1:0]        owner_q;
  logic              ptr_q;       // 0: source 0 wins a normal tie, 1: source 1 wins
  logic [HOLD_W-1:0] hold_cnt_q;
  logic              phase_q;
  logic [CNT_W-1:0]  tick_cnt_q;

  logic              tick;
  logic              hold_done;
  logic [1:0]        sel_d;
  logic              leave_d;

  assign tick      = (tick_cnt_q == CNT_W'(TICK_PERIOD - 1));
  assign hold_done = (hold_cnt_q == HOLD_W'(HOLD_TICKS));

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    sel_d = 2'd3;
    if (req[2])                sel_d = 2'd2;
    else if (req[0] && req[1]) sel_d = {1'b0, ptr_q};
    else if (req[0])           sel_d = 2'd0;
    else if (req[1])           sel_d = 2'd1;
  end

  always_comb begin
    leave_d = 1'b1;
    case (owner_q)
      2'd0:    leave_d = !req[0] || req[2] || (req[1] && hold_done);
      2'd1:    leave_d = !req[1] || req[2] || (req[0] && hold_done);
      2'd2:    leave_d = !req[2];
      default: leave_d = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= 3'b000;
      owner_q    <= 2'd3;
      ptr_q      <= 1'b0;
      hold_cnt_q <= '0;
      phase_q    <= 1'b1;
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + CNT_W'(1);

      case (state_q)
        IDLE, SWITCH: begin
          if (|req) begin
            state_q    <= OWN;
            gnt_q      <= 3'b001 << sel_d;
            owner_q    <= sel_d;
            hold_cnt_q <= '0;
            phase_q    <= 1'b1;
            if (sel_d != 2'd2) ptr_q <= ~sel_d[0];
          end else begin
            state_q <= IDLE;
            gnt_q   <= 3'b000;
            owner_q <= 2'd3;
          end
        end
        OWN: begin
          if (leave_d) begin
            state_q <= SWITCH;
            gnt_q   <= 3'b000;
            owner_q <= 2'd3;
          end else if (tick) begin
            if (!hold_done) hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
            phase_q <= ~phase_q;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 3'b000;
          owner_q <= 2'd3;
        end
      endcase
    end
  end

  // Combinational so a source updating its word is visible in the same cycle.
  always_comb begin
    time_data = BLANK;
    if (state_q == OWN) begin
      case (owner_q)
        2'd0:    time_data = data0;
        2'd1:    time_data = data1;
        2'd2:    time_data = phase_q ? data2 : BLANK;
        default: time_data = BLANK;
      endcase
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with a 4-cycle tick and a 2-tick hold.
// One table walks a continuous sequence; hand-written steps cover async reset and pass-through.
module tb_display_arbiter;

  localparam logic [31:0] D0 = 32'h1234_5678;
  localparam logic [31:0] D1 = 32'h0000_0959;
  localparam logic [31:0] D2 = 32'h00F1_F259;
  localparam logic [31:0] FF = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = 3'b000;
  logic [31:0] data0 = D0;
  logic [31:0] data1 = D1;
  logic [31:0] data2 = D2;
  logic [2:0]  gnt;
  logic [1:0]  owner;
  logic [31:0] time_data;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]  req;
    int          reps;
    logic [2:0]  gnt;
    logic [1:0]  owner;
    logic [31:0] td;
  } vec_t;

  vec_t vecs[23];

  display_arbiter #(.TICK_PERIOD(4), .HOLD_TICKS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data0     (data0),
    .data1     (data1),
    .data2     (data2),
    .gnt       (gnt),
    .owner     (owner),
    .time_data (time_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [2:0] eg, input logic [1:0] eo,
                           input logic [31:0] et);
    check({tag, " gnt"}, {29'd0, gnt}, {29'd0, eg});
    check({tag, " owner"}, {30'd0, owner}, {30'd0, eo});
    check({tag, " time_data"}, time_data, et);
  endtask

  initial begin
    // Edge k after reset release ticks when k % 4 == 0.
    vecs[0]  = '{3'b011, 8,  3'b001, 2'd0, D0};  // edges 1-8: owner 0, contested, holding
    vecs[1]  = '{3'b011, 1,  3'b000, 2'd3, FF};  // edge 9: hold reached, switch gap
    vecs[2]  = '{3'b011, 1,  3'b010, 2'd1, D1};  // edge 10: pointer hands over to 1
    vecs[3]  = '{3'b001, 1,  3'b000, 2'd3, FF};  // edge 11: owner 1 drops at hold 0
    vecs[4]  = '{3'b001, 83, 3'b001, 2'd0, D0};  // edges 12-94: owner 0 uncontested, 20+ ticks
    vecs[5]  = '{3'b101, 1,  3'b000, 2'd3, FF};  // edge 95: alert preempts
    vecs[6]  = '{3'b101, 4,  3'b100, 2'd2, D2};  // edges 96-99: blink on
    vecs[7]  = '{3'b101, 4,  3'b100, 2'd2, FF};  // edges 100-103: blink off
    vecs[8]  = '{3'b101, 4,  3'b100, 2'd2, D2};  // edges 104-107: blink on
    vecs[9]  = '{3'b011, 1,  3'b000, 2'd3, FF};  // edge 108: alert released
    vecs[10] = '{3'b011, 1,  3'b010, 2'd1, D1};  // edge 109: pointer still prefers 1
    vecs[11] = '{3'b000, 1,  3'b000, 2'd3, FF};  // edge 110: switch
    vecs[12] = '{3'b000, 2,  3'b000, 2'd3, FF};  // edges 111-112: idle
    vecs[13] = '{3'b100, 3,  3'b100, 2'd2, D2};  // edges 113-115: alert from idle
    vecs[14] = '{3'b100, 1,  3'b100, 2'd2, FF};  // edge 116: first toggle
    vecs[15] = '{3'b000, 1,  3'b000, 2'd3, FF};  // edge 117: switch
    vecs[16] = '{3'b000, 1,  3'b000, 2'd3, FF};  // edge 118: idle
    vecs[17] = '{3'b010, 1,  3'b010, 2'd1, D1};  // edge 119: owner 1
    vecs[18] = '{3'b110, 1,  3'b000, 2'd3, FF};  // edge 120: preempt at hold 0
    vecs[19] = '{3'b110, 1,  3'b100, 2'd2, D2};  // edge 121: alert owns
    vecs[20] = '{3'b010, 1,  3'b000, 2'd3, FF};  // edge 122: alert drops
    vecs[21] = '{3'b110, 1,  3'b100, 2'd2, D2};  // edge 123: re-request in switch wins again
    vecs[22] = '{3'b110, 0,  3'b100, 2'd2, D2};  // zero repetitions, holds req for the next step

    #7;
    check_out("reset", 3'b000, 2'd3, FF);
    #1 rst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      req = vecs[i].req;
      for (int r = 0; r < vecs[i].reps; r++) begin
        @(posedge clk);
        #1;
        check_out($sformatf("v%0d.%0d", i, r), vecs[i].gnt, vecs[i].owner, vecs[i].td);
      end
    end

    // Source word updates pass straight through while owned.
    data2 = 32'hDEAD_BEEF;
    #1 check("passthrough time_data", time_data, 32'hDEAD_BEEF);
    data2 = D2;

    // Async reset mid-OWN drops the grant before any clock edge.
    #1 rst = 1'b1;
    #1 check_out("async_rst own", 3'b000, 2'd3, FF);
    #3 rst = 1'b0;
    req = 3'b010;
    @(posedge clk); #1;
    check_out("post_rst first edge", 3'b010, 2'd1, D1);

    // Move the pointer to prefer 1, then prove reset restores preference for 0.
    req = 3'b001;
    @(posedge clk); #1;
    check_out("drop to switch", 3'b000, 2'd3, FF);
    @(posedge clk); #1;
    check_out("owner 0 no wait", 3'b001, 2'd0, D0);
    #2 rst = 1'b1;
    #1 check_out("async_rst own0", 3'b000, 2'd3, FF);
    #3 rst = 1'b0;
    req = 3'b011;
    @(posedge clk); #1;
    check_out("ptr reset prefers 0", 3'b001, 2'd0, D0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
